// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty backpressure.
// Define SYNC_FIFO_COUNT_EN to add the registered-derived `count` occupancy port.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
`ifdef SYNC_FIFO_COUNT_EN
    output logic [$clog2(DEPTH):0] count,
`endif
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    // Flags come only from the registered pointers; the MSB is the wrap bit.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);

    // Requests are qualified by the registered flags, so a full FIFO drops writes.
    assign do_wr = w_en && !full;
    assign do_rd = r_en && !empty;

    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

`ifdef SYNC_FIFO_COUNT_EN
    assign count = wr_ptr - rd_ptr;
`endif

    // Storage is written on an accepted write and never reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

    // Pointer update; reset discards all contents immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes expected words,
// a negedge monitor pops and compares whenever a pop is presented.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_COUNT_EN
    logic [$clog2(DEPTH):0] count;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
`ifdef SYNC_FIFO_COUNT_EN
        .count    (count),
`endif
        .empty    (empty)
    );

    int checks = 0;
    int fails  = 0;
    int mcnt   = 0;
    logic [DW-1:0] sbq [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a pop is presented when r_en is high and the FIFO is not empty.
    always @(negedge clk) begin
        if (rst_n && r_en && !empty) begin
            if (sbq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got 0x%0h expected none at %0t", data_out, $time);
            end else begin
                chk("pop_data", int'(data_out), int'(sbq.pop_front()));
            end
        end
    end

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        bit aw;
        bit ar;
        aw = w && (mcnt < DEPTH);
        ar = r && (mcnt > 0);
        w_en    = w;
        r_en    = r;
        data_in = d;
        if (aw) sbq.push_back(d);
        mcnt = mcnt + int'(aw) - int'(ar);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        chk("empty", int'(empty), int'(mcnt == 0));
        chk("full", int'(full), int'(mcnt == DEPTH));
`ifdef SYNC_FIFO_COUNT_EN
        chk("count", int'(count), mcnt);
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;

        // 1: reset held for 10 cycles
        repeat (10) @(posedge clk);
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_data", int'(data_out), 0);
        rst_n = 1'b1;

        // 1b: asynchronous reset mid-operation
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        chk("pre_arst_data", int'(data_out), 8'h11);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", int'(empty), 1);
        chk("arst_full", int'(full), 0);
        chk("arst_data", int'(data_out), 0);
        sbq.delete();
        mcnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 2: fill, overflow write, drain
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        chk("fill_full", int'(full), 1);
        step(1'b1, 1'b0, 8'hFF);
        chk("ovf_head", int'(data_out), 8'h01);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);
        chk("drain_empty", int'(empty), 1);

        // 3: interleaved traffic, two passes
        for (int c = 0; c < 30; c++) begin
            step(c % 2 == 0, c % 2 == 0, DW'($urandom));
        end
        for (int c = 0; c < 30; c++) begin
            step(c % 2 == 0, c % 2 == 1, DW'($urandom));
        end
        while (mcnt > 0) step(1'b0, 1'b1, 8'h00);

        // 4: simultaneous at occupancy 3, then at full
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DW'(8'hB0 + i));
        chk("simul_occ", mcnt, 3);
        while (mcnt < DEPTH) step(1'b1, 1'b0, DW'(8'hC0 + mcnt));
        step(1'b1, 1'b1, 8'hEE);
        chk("full_rw_full", int'(full), 0);
        chk("full_rw_occ", mcnt, DEPTH - 1);
        while (mcnt > 0) step(1'b0, 1'b1, 8'h00);

        // 5: wrap-around with 20 write/read pairs
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, DW'(8'h40 + i));
            step(1'b0, 1'b1, 8'h00);
        end

        // 6: underflow then single write
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hA5);
        chk("uf_data", int'(data_out), 8'hA5);
`ifdef SYNC_FIFO_COUNT_EN
        chk("uf_count", int'(count), 1);
`endif
        step(1'b0, 1'b1, 8'h00);

        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
